// File: rtl/nrdiv_seq_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// State encoding, default operand width and the divide-by-zero quotient fill.
package nrdiv_seq_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StLoad = 3'd1,
      StIter = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } nrdiv_state_e;

   localparam int unsigned DefWidth = 8;

   // A zero divisor returns an all-ones quotient.
   localparam logic DzQuoFill = 1'b1;

endpackage

// File: rtl/nrdiv_addsub.sv
// Combinational WIDTH+1-bit add/subtract for the non-restoring divider.
// Returns the new partial remainder and the quotient bit implied by its sign.
module nrdiv_addsub
   import nrdiv_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] d,
   input  logic             sub,
   output logic [WIDTH:0]   a_new,
   output logic             qbit
);

   logic [WIDTH:0] d_ext;

   always_comb begin
      d_ext = {1'b0, d};
      a_new = sub ? (a - d_ext) : (a + d_ext);
      qbit  = ~a_new[WIDTH];
   end

endmodule

// File: rtl/nrdiv_seq.sv
// Sequential non-restoring divider, one quotient bit per clock, start/done control.
// Define NRDIV_SIGNED_EN for two's-complement operands (truncating division).
module nrdiv_seq
   import nrdiv_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] Q,
   input  logic [WIDTH-1:0] M,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);

   nrdiv_state_e     state_q;
   logic [WIDTH:0]   a_q;
   logic [WIDTH-1:0] qr_q;
   logic [WIDTH-1:0] d_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] q_lat;
   logic [WIDTH-1:0] m_lat;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   as_a;
   logic [WIDTH:0]   as_res;
   logic             as_sub;
   logic             as_qbit;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] m_mag;
   logic [WIDTH-1:0] rem_mag;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   // The single adder shifts-and-steps in ITER and restores the remainder in FIX.
   always_comb begin
      shifted = {a_q[WIDTH-1:0], qr_q[WIDTH-1]};
      if (state_q == StIter) begin
         as_a   = shifted;
         as_sub = ~a_q[WIDTH];
      end else begin
         as_a   = a_q;
         as_sub = 1'b0;
      end
      rem_mag = a_q[WIDTH] ? as_res[WIDTH-1:0] : a_q[WIDTH-1:0];
`ifdef NRDIV_SIGNED_EN
      q_mag   = q_lat[WIDTH-1] ? -q_lat : q_lat;
      m_mag   = m_lat[WIDTH-1] ? -m_lat : m_lat;
      quo_fix = (q_lat[WIDTH-1] ^ m_lat[WIDTH-1]) ? -qr_q : qr_q;
      rem_fix = q_lat[WIDTH-1] ? -rem_mag : rem_mag;
`else
      q_mag   = q_lat;
      m_mag   = m_lat;
      quo_fix = qr_q;
      rem_fix = rem_mag;
`endif
   end

   nrdiv_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a     (as_a),
      .d     (d_q),
      .sub   (as_sub),
      .a_new (as_res),
      .qbit  (as_qbit)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         qr_q    <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         q_lat   <= '0;
         m_lat   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dz      <= 1'b0;
         quo     <= '0;
         rem     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  q_lat   <= Q;
                  m_lat   <= M;
                  quo     <= '0;
                  rem     <= '0;
                  dz      <= 1'b0;
                  busy    <= 1'b1;
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               if (m_lat == '0) begin
                  // Zero divisor skips ITER but still passes FIX, keeping done two edges out.
                  dz      <= 1'b1;
                  quo     <= {WIDTH{DzQuoFill}};
                  rem     <= q_lat;
                  state_q <= StFix;
               end else begin
                  a_q     <= '0;
                  qr_q    <= q_mag;
                  d_q     <= m_mag;
                  cnt_q   <= '0;
                  state_q <= StIter;
               end
            end
            StIter: begin
               a_q   <= as_res;
               qr_q  <= {qr_q[WIDTH-2:0], as_qbit};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               if (!dz) begin
                  quo <= quo_fix;
                  rem <= rem_fix;
               end
               done    <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nrdiv_seq.sv
// Directed-vector bench for nrdiv_seq; expected results are hand-computed.
module tb_nrdiv_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] Q;
   logic [7:0] M;
   logic       busy;
   logic       done;
   logic       dz;
   logic [7:0] quo;
   logic [7:0] rem;

   int n_vec  = 0;
   int n_miss = 0;

   nrdiv_seq #(
      .WIDTH (8),
      .CNT_W (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .Q     (Q),
      .M     (M),
      .busy  (busy),
      .done  (done),
      .dz    (dz),
      .quo   (quo),
      .rem   (rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start at edge 0; pulses bit e drives start before edge e. Runs 16 edges.
   task automatic run_div(input string tag, input logic [7:0] q, input logic [7:0] m,
                          input logic [31:0] pulses, input logic [7:0] eq,
                          input logic [7:0] er, input logic edz, input int elat);
      int done_edge = -1;
      int n_done    = 0;
      int busy_err  = 0;
      logic [7:0] quo_s = 8'h00;
      logic [7:0] rem_s = 8'h00;
      logic       dz_s  = 1'b0;
      for (int e = 0; e < 16; e++) begin
         @(negedge clk);
         Q     = q;
         M     = m;
         start = pulses[e];
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            if (done_edge < 0) begin
               done_edge = e;
               quo_s     = quo;
               rem_s     = rem;
               dz_s      = dz;
            end
         end
         if (busy !== (e <= elat)) busy_err++;
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".latency"}, done_edge, elat);
      chk({tag, ".ndone"}, n_done, 1);
      chk({tag, ".quo"}, quo_s, eq);
      chk({tag, ".rem"}, rem_s, er);
      chk({tag, ".dz"}, dz_s, edz);
      chk({tag, ".busy"}, busy_err, 0);
      chk({tag, ".quo_held"}, quo, eq);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      Q     = 8'h00;
      M     = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.dz", dz, 0);
      chk("reset.quo", quo, 0);
      chk("reset.rem", rem, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      run_div("u100_7", 8'd100, 8'd7, 32'h1, 8'd14, 8'd2, 1'b0, 10);
      run_div("u255_1", 8'd255, 8'd1, 32'h1, 8'd255, 8'd0, 1'b0, 10);
      run_div("u5_9", 8'd5, 8'd9, 32'h1, 8'd0, 8'd5, 1'b0, 10);
      run_div("u0_3", 8'd0, 8'd3, 32'h1, 8'd0, 8'd0, 1'b0, 10);
      run_div("u77_0", 8'd77, 8'd0, 32'h1, 8'hFF, 8'd77, 1'b1, 2);
      run_div("u9_3", 8'd9, 8'd3, 32'h1, 8'd3, 8'd0, 1'b0, 10);
`ifdef NRDIV_SIGNED_EN
      // 200 is -56 here: -56/13 = -4 r -4
      run_div("repulse", 8'd200, 8'd13, 32'h409, 8'hFC, 8'hFC, 1'b0, 10);
`else
      run_div("repulse", 8'd200, 8'd13, 32'h409, 8'd15, 8'd5, 1'b0, 10);
`endif

      // Reset in the middle of an operation
      @(negedge clk);
      Q     = 8'd200;
      M     = 8'd13;
      start = 1'b1;
      @(posedge clk);
      for (int e = 1; e < 5; e++) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.dz", dz, 0);
      chk("midrst.quo", quo, 0);
      chk("midrst.rem", rem, 0);
      @(negedge clk);
      rst = 1'b1;
      run_div("u50_6", 8'd50, 8'd6, 32'h1, 8'd8, 8'd2, 1'b0, 10);

`ifdef NRDIV_SIGNED_EN
      run_div("sn100_7", 8'h9C, 8'd7, 32'h1, 8'hF2, 8'hFE, 1'b0, 10);
      run_div("s100_n7", 8'd100, 8'hF9, 32'h1, 8'hF2, 8'h02, 1'b0, 10);
      run_div("sn128_n1", 8'h80, 8'hFF, 32'h1, 8'h80, 8'h00, 1'b0, 10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
